// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit framer clocked at the baud rate (one bit per CLK).
// Frame on TX_OUT: start bit (0), BUS_WIDTH data bits LSB first taken from the
// external serializer, an optional parity bit, then a stop bit (1).
// Build option: define UART_TX_PARITY_EN to compile in the parity logic and the
// PARITY state. Without it, PAR_EN and PAR_TYP are ignored, and every frame is
// BUS_WIDTH+2 cycles long.
module uart_tx_fsm #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] P_DATA,
    input  logic                 Data_Valid,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 ser_data,
    input  logic                 ser_done,
    output logic                 ser_en,
    output logic                 TX_OUT,
    output logic                 Busy,
    output logic                 ser_err
);

    // One spare bit so the counter can reach BUS_WIDTH without wrapping.
    localparam int               CNT_W    = $clog2(BUS_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 ser_err_q, ser_err_d;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_bit;

    // Parity comes from the word captured at acceptance, never the live bus.
    assign par_bit = (^data_q) ^ par_typ_q;
`else
    // Parity controls and the captured word have no consumer in this build.
    logic unused_par_cfg;
    assign unused_par_cfg = ^{PAR_EN, PAR_TYP, data_q};
`endif

    // Next-state logic: framing sequence, word acceptance and the DATA guard.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        ser_err_d = 1'b0;
        accept    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                // A serializer that never signals done is cut off after
                // BUS_WIDTH bits; a done on that same last bit is a clean exit.
                if (ser_done || (cnt_q == CNT_LAST)) begin
                    ser_err_d = ~ser_done;
`ifdef UART_TX_PARITY_EN
                    state_d   = par_en_q ? PARITY : STOP;
`else
                    state_d   = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_d = STOP;
            end
`endif
            STOP: begin
                // Accepting here lets frames run back to back with no idle gap.
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            data_d    = P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
`endif
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        TX_OUT = 1'b1;
        Busy   = 1'b1;
        ser_en = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
            end
            START: begin
                TX_OUT = 1'b0;
                ser_en = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                ser_en = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                TX_OUT = par_bit;
            end
`endif
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

    assign ser_err = ser_err_q;

    // State, counter and captured-word registers; reset abandons any frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            ser_err_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            ser_err_q <= ser_err_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed and randomized frames for uart_tx_fsm, compared
// cycle by cycle against a frame-level reference model. A small serializer
// model feeds ser_data/ser_done from the words the bench sends.
module tb_uart_tx_fsm;

    localparam int W = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit         PAR_BUILD = 1'b1;
    localparam logic [10:0] A5_EVEN  = 11'b01010010101;
    localparam logic [10:0] A5_ODD   = 11'b01010010111;
`else
    localparam bit         PAR_BUILD = 1'b0;
    localparam logic [10:0] A5_EVEN  = 11'b10101001011;
    localparam logic [10:0] A5_ODD   = 11'b10101001011;
`endif
    localparam logic [10:0] A5_NOPAR = 11'b10101001011;
    localparam logic [19:0] B2B_SEQ  = 20'b00000000010111111111;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         ser_data;
    logic         ser_done;
    logic         ser_en;
    logic         TX_OUT;
    logic         Busy;
    logic         ser_err;

    always #5 CLK = ~CLK;

    uart_tx_fsm #(.BUS_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy),
        .ser_err   (ser_err)
    );

    typedef struct packed {
        logic tx;
        logic busy;
        logic sen;
        logic err;
    } exp_t;

    exp_t         eq[$];
    logic [W-1:0] ser_words[$];
    bit           ser_nodone[$];
    int           ser_rd = 0;
    int           sc = 0;
    logic [W-1:0] cur_word = '0;
    bit           cur_nodone = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          err_seen = 0;
    logic [31:0] tx_hist = '0;

    function automatic logic bit_at(input logic [W-1:0] w, input int i);
        logic [W-1:0] s;
        s = w >> i;
        return s[0];
    endfunction

    // Serializer model: counts enabled cycles, presents bit i in the i-th
    // cycle after the start cycle, and flags done on the last bit.
    always @(posedge CLK) begin
        if (ser_en === 1'b1) begin
            sc <= sc + 1;
            if (sc == 0 && ser_rd < ser_words.size()) begin
                cur_word   <= ser_words[ser_rd];
                cur_nodone <= ser_nodone[ser_rd];
                ser_rd     <= ser_rd + 1;
            end
        end else begin
            sc <= 0;
        end
    end

    assign ser_data = (sc >= 1 && sc <= W) ? bit_at(cur_word, sc - 1) : 1'b0;
    assign ser_done = (!cur_nodone) && (sc == W);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word and queue the whole frame the line should carry.
    task automatic start_frame(input logic [W-1:0] w, input bit pen, input bit ptyp, input bit nodone);
        int ones;
        P_DATA     = w;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        ser_words.push_back(w);
        ser_nodone.push_back(nodone);
        eq.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < W; i++) eq.push_back('{bit_at(w, i), 1'b1, 1'b1, 1'b0});
        ones = $countones(w);
        if (PAR_BUILD && pen) begin
            eq.push_back('{(((ones % 2) == 1) != ptyp), 1'b1, 1'b0, nodone});
            eq.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        end else begin
            eq.push_back('{1'b1, 1'b1, 1'b0, nodone});
        end
    endtask

    // Advance one cycle and compare outputs mid-cycle.
    task automatic step(input string tag);
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (eq.size() > 0) e = eq.pop_front();
        else e = '{1'b1, 1'b0, 1'b0, 1'b0};
        tx_hist = {tx_hist[30:0], TX_OUT};
        if (ser_err === 1'b1) err_seen++;
        chk($sformatf("%s_tx@%0d", tag, cyc), 32'(TX_OUT), 32'(e.tx));
        chk($sformatf("%s_busy@%0d", tag, cyc), 32'(Busy), 32'(e.busy));
        chk($sformatf("%s_ser_en@%0d", tag, cyc), 32'(ser_en), 32'(e.sen));
        chk($sformatf("%s_ser_err@%0d", tag, cyc), 32'(ser_err), 32'(e.err));
    endtask

    // mode 0: drop Data_Valid; 1: scramble inputs mid-frame; 2: hold them.
    task automatic finish_frame(input string tag, input int mode);
        int n;
        n = eq.size();
        for (int i = 0; i < n; i++) begin
            step(tag);
            if (eq.size() == 0 || mode == 0) begin
                Data_Valid = 1'b0;
            end else if (mode == 1) begin
                Data_Valid = 1'($urandom_range(0, 1));
                P_DATA     = W'($urandom);
                PAR_EN     = 1'($urandom_range(0, 1));
                PAR_TYP    = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int err_before;
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_ser_en", 32'(ser_en), 32'd0);
        chk("reset_ser_err", 32'(ser_err), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        step("idle");
        step("idle");

        start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        finish_frame("a5_even", 0);
        chk("a5_even_seq", 32'(tx_hist[10:0]), 32'(A5_EVEN));
        step("idle");

        start_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        finish_frame("a5_odd", 0);
        chk("a5_odd_seq", 32'(tx_hist[10:0]), 32'(A5_ODD));
        step("idle");

        start_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        finish_frame("a5_nopar", 0);
        chk("a5_nopar_seq", 32'(tx_hist[10:0]), 32'(A5_NOPAR));
        step("idle");

        start_frame(8'h00, 1'b0, 1'b0, 1'b0);
        finish_frame("b2b_00", 2);
        start_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        finish_frame("b2b_ff", 0);
        chk("b2b_seq", 32'(tx_hist[19:0]), 32'(B2B_SEQ));
        step("idle");

        start_frame(8'h96, 1'b1, 1'b0, 1'b0);
        finish_frame("midchg", 1);
        step("midchg_idle");
        step("midchg_idle");

        err_before = err_seen;
        start_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        finish_frame("guard", 0);
        step("guard_idle");
        chk("guard_err_pulses", 32'(err_seen - err_before), 32'd1);

        start_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        step("rst_start");
        Data_Valid = 1'b0;
        step("rst_b0");
        step("rst_b1");
        step("rst_b2");
        #1 RST = 1'b0;
        #1;
        chk("rst_async_tx", 32'(TX_OUT), 32'd1);
        chk("rst_async_busy", 32'(Busy), 32'd0);
        chk("rst_async_ser_en", 32'(ser_en), 32'd0);
        chk("rst_async_ser_err", 32'(ser_err), 32'd0);
        eq.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        step("post_rst_idle");
        step("post_rst_idle");
        start_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        finish_frame("x3c", 0);
        step("x3c_idle");

        for (int f = 0; f < 24; f++) begin
            logic [W-1:0] w;
            bit           pen;
            bit           ptyp;
            bit           nod;
            int           gap;
            w    = W'($urandom);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            nod  = ($urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 2);
            repeat (gap) step("rnd_gap");
            start_frame(w, pen, ptyp, nod);
            finish_frame("rnd", 1);
        end
        step("final_idle");
        step("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

UART transmit controller that frames one parallel word per transaction into start, data, optional parity and stop bits. It accepts words from the upstream data source and drives the serializer's enable. It consumes the serializer's bit stream and done flag, and produces the line output TX_OUT. The block is clocked at the baud rate, so each bit lasts exactly one CLK cycle.

## Interface
- BUS_WIDTH, 8, data word width; must match the serializer.
- CLK  in  1  baud-rate clock; all state changes on the rising edge.
- RST  in  1  reset; one clock, asynchronous and active-low.
- P_DATA  in  BUS_WIDTH  word to send; valid while Data_Valid is high.
- Data_Valid  in  1  request to transmit P_DATA.
- PAR_EN  in  1  1 inserts a parity bit.
- PAR_TYP  in  1  0 selects even parity, 1 selects odd.
- ser_data  in  1  current data bit from the serializer.
- ser_done  in  1  serializer is presenting its last data bit this cycle.
- ser_en  out  1  serializer enable.
- TX_OUT  out  1  serial line output; idle level is 1.
- Busy  out  1  frame in progress.
- ser_err  out  1  one-cycle pulse when the serializer overrun guard fires.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is registered.
- TX_OUT is decoded from the registered state:
  - IDLE and STOP drive 1.
  - START drives 0.
  - DATA drives ser_data.
  - PARITY drives par_bit.
- Busy is 1 in every state except IDLE.
- ser_en is 1 in START and DATA, 0 otherwise.
- Word acceptance: when Data_Valid=1 and state is IDLE or STOP, the block:
  - latches P_DATA, PAR_EN and PAR_TYP;
  - computes par_bit = (XOR of the data bits) XOR PAR_TYP;
  - moves to START.
- Data_Valid is ignored in START, DATA and PARITY. No queuing; upstream holds or drops the word.
- START moves to DATA unconditionally after 1 cycle. The internal counter cnt is cleared to 0.
- In DATA, cnt increments each cycle.
  - Exit on ser_done=1, or on cnt=BUS_WIDTH-1 without ser_done (guard).
  - Next state is PARITY if the latched PAR_EN=1, otherwise STOP.
  - When the guard fires, ser_err=1 for exactly the first cycle after exit.
- PARITY moves to STOP after 1 cycle.
- STOP moves to START if Data_Valid=1 (back-to-back, no idle gap), otherwise to IDLE.
- Width rules:
  - cnt is $clog2(BUS_WIDTH)+1 bits and never wraps within a frame.
  - par_bit is computed from the latched copy only, never from live P_DATA.

## Timing
- Reset values: state=IDLE, TX_OUT=1, Busy=0, ser_en=0, ser_err=0, cnt=0, latched data=0.
- Reset asserted mid-frame forces TX_OUT=1 asynchronously. The partial frame is abandoned.
- Acceptance at edge k gives:
  - TX_OUT=0, Busy=1 and ser_en=1 during cycle k;
  - data bits during cycles k+1 to k+BUS_WIDTH;
  - parity, if enabled, during cycle k+BUS_WIDTH+1;
  - stop during the following cycle.
- Frame length is BUS_WIDTH+2 cycles, or BUS_WIDTH+3 with parity.
- Serializer contract: bit i (LSB first) is on ser_data in the i-th DATA cycle, and ser_done=1 in the last DATA cycle.
- Simultaneous ser_done and guard expiry counts as a normal exit: no ser_err.
- Back-to-back frames: the next start bit immediately follows the stop bit, so the line stays at 1 for exactly 1 cycle.

## Configuration
- UART_TX_PARITY_EN defined: parity logic and the PARITY state are compiled in, and PAR_EN and PAR_TYP behave as specified.
- UART_TX_PARITY_EN undefined:
  - PAR_EN and PAR_TYP are ignored and the PARITY state is removed;
  - DATA always moves to STOP;
  - every frame is BUS_WIDTH+2 cycles.
- The ports are present in both builds.

## Test plan
- Reset, then P_DATA=0xA5, Data_Valid pulse, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence is 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1. Busy is high for 11 cycles, then returns to 0.
- Same word with PAR_TYP=1 -> parity bit is 1. With PAR_EN=0 -> 10-cycle frame with no parity bit.
- Data_Valid held high with 0x00 then 0xFF, PAR_EN=0 -> the two frames are contiguous: stop(1) is followed directly by start(0). Busy never drops between them. 0xFF produces eight 1s.
- Change P_DATA and PAR_TYP mid-frame while Data_Valid=1 -> the frame in flight is unaffected and no extra frame starts before STOP.
- Serializer model that never asserts ser_done -> DATA exits after 8 cycles, ser_err pulses once, and the frame completes with a stop bit.
- RST asserted low during the third data bit -> TX_OUT=1, Busy=0 and ser_en=0 immediately. After release, 0x3C transmits correctly.
